// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger scoring blocks: tally FSM states and
// default timing/scoring constants.
package frogger_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        TALLY   = 2'd2,
        DONE    = 2'd3
    } tally_state_t;

    // 50 MHz clock / 2_500_000 = 20 tallied seconds per real second.
    localparam int DEF_TICK_DIV       = 2500000;
    localparam int DEF_POINTS_PER_SEC = 10;
    localparam int DEF_BONUS_W        = 16;

endpackage : frogger_pkg

// File: rtl/time_bonus_if.sv
// Game-control and score signals exchanged between the game controller
// (master) and the time bonus block (slave).
interface time_bonus_if #(
    parameter int BONUS_W = 16
) ();
    logic               gameStart;
    logic               gameEnd;
    logic               levelDone;
    logic [5:0]         tim;
    logic [5:0]         sec_left;
    logic [BONUS_W-1:0] bonus;
    logic               tally_active;
    logic               tally_done;
    logic               timeout;

    modport master (
        output gameStart, gameEnd, levelDone, tim,
        input  sec_left, bonus, tally_active, tally_done, timeout
    );

    modport slave (
        input  gameStart, gameEnd, levelDone, tim,
        output sec_left, bonus, tally_active, tally_done, timeout
    );
endinterface : time_bonus_if

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter used to pace the bonus tally. wrap is
// high during the enabled cycle in which the counter sits at DIV-1, so the
// consumer acts on the same edge the counter returns to zero.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic wrap
);
    localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Count enabled cycles, restart after DIV-1 or on clear.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule : tick_divider

// File: rtl/time_bonus.sv
// End-of-level time bonus: on levelDone the remaining seconds are captured
// and tallied one per TICK_DIV cycles into a saturating bonus score.
// Also flags the moment the level timer runs out during play.
module time_bonus
    import frogger_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int POINTS_PER_SEC = DEF_POINTS_PER_SEC,
    parameter int BONUS_W        = DEF_BONUS_W
) (
    input  logic         clk,
    input  logic         Reset,
    time_bonus_if.slave  bus
);
    tally_state_t       state;
    logic [5:0]         sec_left_q;
    logic [BONUS_W-1:0] bonus_q;
    logic [5:0]         prev_tim;
    logic               tally_active_q;
    logic               tally_done_q;
    logic               timeout_q;

    logic abort;
    logic tick_clr;
    logic tick_en;
    logic tick_wrap;

    // Adds one second's worth of points, clamping at all-ones.
    function automatic logic [BONUS_W-1:0] sat_add(input logic [BONUS_W-1:0] a);
        logic [BONUS_W:0] sum;
        sum = {1'b0, a} + (BONUS_W + 1)'(POINTS_PER_SEC);
        return sum[BONUS_W] ? {BONUS_W{1'b1}} : sum[BONUS_W-1:0];
    endfunction

    // Leaving play (game over or no game) preempts everything else.
    assign abort    = bus.gameEnd || !bus.gameStart;
    assign tick_clr = (state == CAPTURE);
    assign tick_en  = (state == TALLY) && !abort;

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .Reset (Reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .wrap  (tick_wrap)
    );

    // Tally FSM with registered status outputs and timeout edge detect.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state          <= IDLE;
            sec_left_q     <= '0;
            bonus_q        <= '0;
            prev_tim       <= '0;
            tally_active_q <= 1'b0;
            tally_done_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            tally_done_q <= 1'b0;
            prev_tim     <= bus.tim;
            // Only a falling-to-zero transition counts, so holding 0 stays quiet.
            timeout_q    <= (prev_tim != 6'd0) && (bus.tim == 6'd0) &&
                            bus.gameStart && !bus.gameEnd && (state == IDLE);

            if (abort) begin
                state          <= IDLE;
                sec_left_q     <= '0;
                tally_active_q <= 1'b0;
                if (!bus.gameStart) begin
                    bonus_q <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.levelDone) begin
                            sec_left_q     <= bus.tim;
                            tally_active_q <= 1'b1;
                            state          <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (sec_left_q == 6'd0) begin
                            tally_active_q <= 1'b0;
                            tally_done_q   <= 1'b1;
                            state          <= DONE;
                        end else begin
                            state <= TALLY;
                        end
                    end
                    TALLY: begin
                        if (tick_wrap) begin
                            sec_left_q <= sec_left_q - 6'd1;
                            bonus_q    <= sat_add(bonus_q);
                            if (sec_left_q == 6'd1) begin
                                tally_active_q <= 1'b0;
                                tally_done_q   <= 1'b1;
                                state          <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sec_left     = sec_left_q;
    assign bus.bonus        = bonus_q;
    assign bus.tally_active = tally_active_q;
    assign bus.tally_done   = tally_done_q;
    assign bus.timeout      = timeout_q;

endmodule : time_bonus

// File: tb/tb_time_bonus.sv
// Bench for time_bonus: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a timing-formula
// model of the tally.
module tb_time_bonus;
    localparam int TD   = 4;
    localparam int PPS  = 10;
    localparam int BW   = 16;
    localparam int BMAX = (1 << BW) - 1;

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    time_bonus_if #(.BONUS_W(BW)) bus ();

    time_bonus #(
        .TICK_DIV       (TD),
        .POINTS_PER_SEC (PPS),
        .BONUS_W        (BW)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > BMAX) ? BMAX : v;
    endfunction

    // Model: a tally captured at edge m_start with k seconds finishes
    // (DONE) at elapsed edge 1+k*TD; second j is credited at edge 1+j*TD.
    int m_busy = 0, m_start = 0, m_k = 0, m_base = 0, m_bonus = 0;
    int m_sec = 0, m_prev = 0, edge_n = 0;
    int m_active = 0, m_done = 0, m_to = 0;
    int t_abort, t_idle, t_e, t_kend, t_s;

    initial begin
        forever begin
            @(posedge clk or negedge Reset);
            if (!Reset) begin
                m_busy = 0; m_sec = 0; m_bonus = 0; m_prev = 0;
                m_active = 0; m_done = 0; m_to = 0;
            end else begin
                t_abort = (bus.gameEnd || !bus.gameStart) ? 1 : 0;
                t_idle  = (m_busy == 0) ? 1 : 0;
                edge_n++;
                m_to   = (m_prev != 0 && bus.tim == 0 && bus.gameStart && !bus.gameEnd
                          && t_idle == 1) ? 1 : 0;
                m_prev = int'(bus.tim);
                m_done = 0;
                if (t_abort == 1) begin
                    m_busy = 0; m_sec = 0; m_active = 0;
                    if (!bus.gameStart) m_bonus = 0;
                end else if (t_idle == 1) begin
                    if (bus.levelDone) begin
                        m_busy = 1; m_start = edge_n; m_k = int'(bus.tim);
                        m_base = m_bonus; m_sec = m_k; m_active = 1;
                    end
                end else begin
                    t_e    = edge_n - m_start;
                    t_kend = 1 + m_k * TD;
                    if (t_e > t_kend) begin
                        m_busy = 0; m_active = 0;
                    end else begin
                        t_s = (t_e - 1) / TD;
                        if (t_s > m_k) t_s = m_k;
                        m_sec    = m_k - t_s;
                        m_bonus  = sat(m_base + t_s * PPS);
                        m_active = (t_e < t_kend) ? 1 : 0;
                        m_done   = (t_e == t_kend) ? 1 : 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("sec_left",     32'(bus.sec_left),     32'(m_sec));
            chk("bonus",        32'(bus.bonus),        32'(m_bonus));
            chk("tally_active", 32'(bus.tally_active), 32'(m_active));
            chk("tally_done",   32'(bus.tally_done),   32'(m_done));
            chk("timeout",      32'(bus.timeout),      32'(m_to));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_level(input int t);
        bus.tim       = 6'(t);
        bus.levelDone = 1'b1;
        cyc(1);
        bus.levelDone = 1'b0;
    endtask

    task automatic do_tally(input int k);
        int ok;
        ok = 0;
        pulse_level(k);
        for (int i = 0; i < k * TD + 10; i++) begin
            if (bus.tally_done && ok == 0) ok = 1;
            cyc(1);
        end
        chk("tally_finish", 32'(ok), 32'd1);
    endtask

    int got, cnt, found;

    initial begin
        bus.gameStart = 1'b0;
        bus.gameEnd   = 1'b0;
        bus.levelDone = 1'b0;
        bus.tim       = 6'd0;
        #1 Reset = 1'b0;
        #2;
        chk("rst_sec_left", 32'(bus.sec_left), 32'd0);
        chk("rst_bonus",    32'(bus.bonus),    32'd0);
        chk("rst_active",   32'(bus.tally_active), 32'd0);
        chk("rst_done",     32'(bus.tally_done),   32'd0);
        chk("rst_timeout",  32'(bus.timeout),      32'd0);
        cyc(2);
        Reset = 1'b1;
        bus.gameStart = 1'b1;
        cyc(2);

        // Three-second tally from zero bonus.
        pulse_level(3);
        chk("t3_capture_sec", 32'(bus.sec_left), 32'd3);
        chk("t3_capture_act", 32'(bus.tally_active), 32'd1);
        got = 0; cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (bus.tally_done) begin
                cnt++;
                if (got == 0) got = i;
            end
            cyc(1);
        end
        chk("t3_done_cycle", 32'(got), 32'd14);
        chk("t3_done_count", 32'(cnt), 32'd1);
        chk("t3_bonus", 32'(bus.bonus), 32'd30);

        // Zero seconds captured together with tim falling to zero.
        pulse_level(0);
        got = 0; cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            if (bus.tally_done && got == 0) got = i;
            if (bus.timeout) cnt++;
            cyc(1);
        end
        chk("t0_done_cycle", 32'(got), 32'd2);
        chk("t0_timeout_cnt", 32'(cnt), 32'd1);
        chk("t0_bonus", 32'(bus.bonus), 32'd30);

        // Timeout fires once and stays quiet while tim holds zero.
        bus.tim = 6'd1;
        cyc(3);
        bus.tim = 6'd0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.timeout) cnt++;
            cyc(1);
        end
        chk("timeout_count", 32'(cnt), 32'd1);

        // gameEnd mid-tally at sec_left=5.
        pulse_level(8);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (bus.sec_left == 6'd5) found = 1;
            else cyc(1);
        end
        chk("end_reach5", 32'(found), 32'd1);
        bus.gameEnd = 1'b1;
        cyc(1);
        bus.gameEnd = 1'b0;
        chk("end_sec_left", 32'(bus.sec_left), 32'd0);
        chk("end_active", 32'(bus.tally_active), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.tally_done) cnt++;
            cyc(1);
        end
        chk("end_no_done", 32'(cnt), 32'd0);
        chk("end_bonus_kept", 32'(bus.bonus), 32'd60);
        bus.gameStart = 1'b0;
        cyc(1);
        chk("newgame_bonus", 32'(bus.bonus), 32'd0);
        bus.gameStart = 1'b1;
        cyc(1);

        // Second levelDone ignored, then asynchronous reset mid-tally.
        pulse_level(5);
        cyc(3);
        pulse_level(9);
        cyc(2);
        chk("ignore_level", 32'(bus.sec_left > 6'd5), 32'd0);
        @(posedge clk);
        #4 Reset = 1'b0;
        #1;
        chk("arst_sec_left", 32'(bus.sec_left), 32'd0);
        chk("arst_bonus",    32'(bus.bonus),    32'd0);
        chk("arst_active",   32'(bus.tally_active), 32'd0);
        chk("arst_done",     32'(bus.tally_done),   32'd0);
        cyc(2);
        Reset = 1'b1;
        cyc(2);

        // Saturation: build up 65530 then overflow.
        for (int i = 0; i < 109; i++) do_tally(60);
        do_tally(13);
        chk("sat_preload", 32'(bus.bonus), 32'd65530);
        do_tally(2);
        chk("sat_max", 32'(bus.bonus), 32'd65535);
        do_tally(1);
        chk("sat_hold", 32'(bus.bonus), 32'd65535);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            Reset         = ($urandom_range(0, 499) != 0);
            bus.gameStart = ($urandom_range(0, 99) > 2);
            bus.gameEnd   = ($urandom_range(0, 99) < 2);
            bus.levelDone = ($urandom_range(0, 99) < 10);
            bus.tim       = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 60))
                                                        : 6'($urandom_range(0, 3));
            cyc(1);
        end
        Reset = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_time_bonus

// File: doc/time_bonus.md
TIME_BONUS -- requirements
Module: time_bonus

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2500000, clk cycles per tallied second (20 tallies/s at 50 MHz).
REQ-002 SHALL have parameter POINTS_PER_SEC, default 10, bonus points added per tallied second.
REQ-003 SHALL have parameter BONUS_W, default 16, width of the bonus accumulator.
REQ-004 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port gameStart  input  1  high while a game is in progress.
REQ-007 SHALL have port gameEnd  input  1  high once the game is over.
REQ-008 SHALL have port levelDone  input  1  one-cycle pulse when the frog completes a level.
REQ-009 SHALL have port tim  input  6  seconds remaining from the level countdown timer, 0..60.
REQ-010 SHALL have port sec_left  output  6  seconds still to be tallied.
REQ-011 SHALL have port bonus  output  BONUS_W  accumulated time bonus for the current game.
REQ-012 SHALL have port tally_active  output  1  high in CAPTURE and TALLY.
REQ-013 SHALL have port tally_done  output  1  one-cycle pulse when a tally completes.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when tim falls to 0 during play.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, TALLY, DONE.
REQ-016 In IDLE, on levelDone=1 with gameStart=1 and gameEnd=0, SHALL load sec_left<=tim and enter CAPTURE next cycle.
REQ-017 In CAPTURE (one cycle), SHALL clear the tick counter; go to DONE if sec_left==0, else TALLY.
REQ-018 In TALLY, tick counter SHALL count 0..TICK_DIV-1 and wrap; on each wrap sec_left decrements by 1 and bonus adds POINTS_PER_SEC in the same cycle.
REQ-019 SHALL enter DONE on the wrap that decrements sec_left from 1 to 0.
REQ-020 In DONE, tally_done SHALL be 1 for exactly that cycle; next state IDLE.
REQ-021 Tally of k>0 seconds SHALL take exactly 1 (CAPTURE) + k*TICK_DIV (TALLY) cycles before DONE.
REQ-022 bonus SHALL saturate at 2^BONUS_W-1; no wrap-around.
REQ-023 levelDone outside IDLE SHALL be ignored.
REQ-024 tim sampled only at capture; later tim changes SHALL not affect sec_left.
REQ-025 gameEnd=1 or gameStart=0 in any state SHALL force IDLE next cycle with sec_left<=0, tally_done=0; bonus unaffected by gameEnd.
REQ-026 gameStart=0 SHALL clear bonus to 0 (new game); bonus SHALL persist across levels while gameStart=1.
REQ-027 timeout SHALL pulse one cycle when registered prev_tim!=0, tim==0, gameStart=1, gameEnd=0, state IDLE; no repeat while tim stays 0.
REQ-028 levelDone and the timeout condition in the same cycle SHALL both act: capture of 0 seconds and timeout pulse.

Reset
REQ-029 Reset=0 SHALL asynchronously force state IDLE, sec_left=0, bonus=0, tick counter=0, prev_tim=0, all pulse outputs 0.
REQ-030 Reset asserted mid-TALLY SHALL abandon the tally with no tally_done pulse; operation resumes at IDLE on first clk after release.

Structure
REQ-031 State enum (IDLE, CAPTURE, TALLY, DONE) and default TICK_DIV/POINTS_PER_SEC constants SHALL live in shared package frogger_pkg.
REQ-032 Tick counter SHALL be sub-module tick_divider (params DIV; inputs clk, Reset, clr, en; output wrap pulse).

Verification (bench uses TICK_DIV=4, POINTS_PER_SEC=10, BONUS_W=16)
REQ-033 tim=3, levelDone pulse -> CAPTURE 1 cycle, 12 TALLY cycles, sec_left 3->2->1->0, bonus 0->30, tally_done pulse on cycle 14 after levelDone.
REQ-034 tim=0 at levelDone -> CAPTURE then DONE, tally_done 2 cycles after levelDone, bonus unchanged.
REQ-035 Preload bonus 65530 via repeated tallies, tally tim=2 -> bonus=65535, saturated.
REQ-036 gameEnd asserted mid-TALLY at sec_left=5 -> IDLE next cycle, sec_left=0, no tally_done, bonus retained; gameStart=0 -> bonus=0.
REQ-037 tim 1->0 during play -> single timeout pulse; tim held 0 for 10 cycles -> no further pulses.
REQ-038 Reset low mid-TALLY -> outputs 0 immediately without clk edge; second levelDone during TALLY ignored.
